// File: rtl/riscv_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and the
// round-robin "last grant" marker.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// alternating on contention and aborting accesses the memory never completes.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    grant_t            r_last_grant;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_inc;
    logic              r_timed_out;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_grant_if;
    logic              w_grant_d;
    logic              w_busy;
    logic              w_abort;

    assign w_busy     = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_wait_inc = r_wait_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fetch wins a tie unless it was the previous grant.
    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_d    = 1'b0;
        w_abort      = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        if_ack       = 1'b0;
        d_ack        = 1'b0;
        err          = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req && (!d_req || (r_last_grant == GRANT_DATA))) begin
                    w_grant_if   = 1'b1;
                    w_next_state = BUSY_I;
                end else if (d_req) begin
                    w_grant_d    = 1'b1;
                    w_next_state = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                mem_req = 1'b1;
                mem_we  = (r_state == BUSY_D) && r_we;
                if (mem_ready) begin
                    w_next_state = RESP;
                end else if (w_wait_inc == CNT_LAST) begin
                    w_abort      = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if_ack       = (r_last_grant == GRANT_FETCH);
                d_ack        = (r_last_grant == GRANT_DATA);
                err          = r_timed_out;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= GRANT_DATA;
            r_wait_cnt   <= '0;
            r_timed_out  <= 1'b0;
        end else if (w_grant_if || w_grant_d) begin
            r_last_grant <= w_grant_if ? GRANT_FETCH : GRANT_DATA;
            r_wait_cnt   <= '0;
            r_timed_out  <= 1'b0;
        end else if (w_busy && !mem_ready) begin
            r_wait_cnt  <= w_wait_inc;
            r_timed_out <= w_abort;
        end
    end

    // Command fields are frozen at grant so the memory sees a stable request.
    always_ff @(posedge clk) begin
        if (w_grant_if) begin
            r_addr <= if_addr;
            r_we   <= 1'b0;
        end else if (w_grant_d) begin
            r_addr  <= d_addr;
            r_we    <= d_we;
            r_wdata <= d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (mem_ready) begin
            if (r_state == BUSY_I) begin
                r_if_rdata <= mem_rdata;
            end
            if ((r_state == BUSY_D) && !r_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall     = (if_req && !if_ack) || (d_req && !d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level memory/requester model.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall;

    int          n_vec;
    int          n_bad;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
    logic [31:0] mem_model [0:63];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        tick; tick;
        @(negedge clk);
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got %0b want 0", mem_req); end
        n_vec++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got %0b want 0", mem_we); end
        n_vec++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin n_bad++; $display("FAIL rst_acks got %0b%0b want 00", if_ack, d_ack); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0b want 0", err); end
        n_vec++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h/%h want 0/0", if_rdata, d_rdata); end
        n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall got %0b want 1", stall); end
        tick;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        tick;
        reset = 1'b0;
        exp_if = 32'h0; exp_d = 32'h0;
    endtask

    task automatic test_fetch;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_req !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL fetch_c1 got req=%0b stall=%0b want 0/1", mem_req, stall); end
        tick;
        @(negedge clk);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin n_bad++; $display("FAIL fetch_c2 got req=%0b addr=%h we=%0b want 1/10/0", mem_req, mem_addr, mem_we); end
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        tick;
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_vec++; if (if_ack !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL fetch_ack_c3 got ack=%0b err=%0b want 1/0", if_ack, err); end
        n_vec++; if (if_rdata !== 32'h0050_0093) begin n_bad++; $display("FAIL fetch_rdata got %h want 00500093", if_rdata); end
        n_vec++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL fetch_c3 got req=%0b stall=%0b want 0/0", mem_req, stall); end
        tick;
        if_req = 1'b0;
        @(negedge clk);
        n_vec++; if (if_ack !== 1'b0 || stall !== 1'b0 || if_rdata !== 32'h0050_0093) begin n_bad++; $display("FAIL fetch_after got ack=%0b stall=%0b rdata=%h want 0/0/00500093", if_ack, stall, if_rdata); end
        exp_if = 32'h0050_0093;
        tick;
    endtask

    // Drives one or both requesters, completes every access immediately and
    // reports the grant order (1 = fetch, 2 = data) and number of acks seen.
    task automatic serve_round(input logic use_if, input logic use_d,
                               output logic [1:0] first, output logic [1:0] second,
                               output int nacks);
        logic pi, pd;
        int   ng;
        first = 2'd0; second = 2'd0; nacks = 0; ng = 0;
        pi = use_if; pd = use_d;
        if_req = use_if; if_addr = 32'h100;
        d_req = use_d; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 0; c < 30 && (pi || pd); c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (if_ack) begin pi = 1'b0; nacks++; end
            if (d_ack) begin pd = 1'b0; nacks++; end
            if (mem_req) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr ^ 32'hA5A5_0000;
                if (ng == 0) first = (mem_addr == 32'h100) ? 2'd1 : 2'd2;
                else if (ng == 1) second = (mem_addr == 32'h100) ? 2'd1 : 2'd2;
                ng++;
            end
            tick;
            if (!pi) if_req = 1'b0;
            if (!pd) d_req = 1'b0;
        end
        mem_ready = 1'b0; if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_tie_order;
        logic [1:0] f, s;
        int         n;
        reset = 1'b1; tick; tick; reset = 1'b0;
        serve_round(1'b1, 1'b1, f, s, n);
        n_vec++; if (f !== 2'd1 || s !== 2'd2 || n != 2) begin n_bad++; $display("FAIL tie_first got %0d,%0d acks=%0d want 1,2 acks=2", f, s, n); end
        serve_round(1'b1, 1'b0, f, s, n);
        n_vec++; if (f !== 2'd1 || n != 1) begin n_bad++; $display("FAIL solo_fetch got %0d acks=%0d want 1 acks=1", f, n); end
        serve_round(1'b1, 1'b1, f, s, n);
        n_vec++; if (f !== 2'd2 || s !== 2'd1 || n != 2) begin n_bad++; $display("FAIL tie_alternate got %0d,%0d acks=%0d want 2,1 acks=2", f, s, n); end
        exp_if = 32'hA5A5_0100; exp_d = 32'hA5A5_0200;
        @(negedge clk);
        n_vec++; if (if_rdata !== exp_if || d_rdata !== exp_d) begin n_bad++; $display("FAIL tie_rdata got %h/%h want %h/%h", if_rdata, d_rdata, exp_if, exp_d); end
        tick;
    endtask

    task automatic test_store;
        int busy, acks;
        busy = 0; acks = 0;
        if_req = 1'b0; mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (d_ack) begin
                acks++;
                n_vec++; if (d_rdata !== exp_d) begin n_bad++; $display("FAIL store_rdata got %h want %h", d_rdata, exp_d); end
            end
            if (mem_req) begin
                busy++;
                n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL store_fields cyc%0d got we=%0b addr=%h wdata=%h want 1/40/deadbeef", busy, mem_we, mem_addr, mem_wdata); end
                if (busy == 4) begin mem_ready = 1'b1; mem_rdata = 32'h1234_5678; end
            end
            tick;
            if (acks > 0) d_req = 1'b0;
            else if (busy >= 1) begin d_addr = $urandom; d_wdata = $urandom; d_we = 1'b0; end
        end
        n_vec++; if (busy != 4 || acks != 1) begin n_bad++; $display("FAIL store_timing got busy=%0d acks=%0d want 4/1", busy, acks); end
        n_vec++; if (d_rdata !== exp_d) begin n_bad++; $display("FAIL store_rdata_hold got %h want %h", d_rdata, exp_d); end
    endtask

    task automatic test_timeout;
        int busy, acks, errs, together;
        busy = 0; acks = 0; errs = 0; together = 0;
        d_req = 1'b0; mem_ready = 1'b0;
        if_req = 1'b1; if_addr = 32'h20;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_req) busy++;
            if (err) errs++;
            if (if_ack) begin
                acks++;
                if (err) together++;
                n_vec++; if (mem_req !== 1'b0 || if_rdata !== exp_if) begin n_bad++; $display("FAIL timeout_resp got req=%0b rdata=%h want 0/%h", mem_req, if_rdata, exp_if); end
            end
            tick;
            if (acks > 0) if_req = 1'b0;
        end
        n_vec++; if (busy != TIMEOUT - 1) begin n_bad++; $display("FAIL timeout_busy got %0d want %0d", busy, TIMEOUT - 1); end
        n_vec++; if (acks != 1 || errs != 1 || together != 1) begin n_bad++; $display("FAIL timeout_err got acks=%0d errs=%0d together=%0d want 1/1/1", acks, errs, together); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        seen = 1'b0;
        if_req = 1'b0; mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
            tick;
        end
        n_vec++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rmid_grant got %0b want 1", seen); end
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick;
        reset = 1'b0; mem_ready = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_req !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rmid_abort got req=%0b ack=%0b err=%0b want 0/0/0", mem_req, d_ack, err); end
        n_vec++; if (d_rdata !== 32'h0) begin n_bad++; $display("FAIL rmid_rdata got %h want 0", d_rdata); end
        for (int c = 0; c < 3; c++) begin
            tick;
            @(negedge clk);
            n_vec++; if (d_ack !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_quiet%0d got ack=%0b err=%0b req=%0b want 0/0/0", c, d_ack, err, mem_req); end
        end
        tick;
        exp_if = 32'h0; exp_d = 32'h0;
    endtask

    // Model: a port that is granted owns the memory until ready or until
    // TIMEOUT-1 wait cycles elapse; its ack follows one cycle later, then one
    // idle cycle samples the requests again (alternating on a tie).
    task automatic test_random(input int ncyc);
        int          phase, gport, busy_n, wait_n, last_port, exp_ack;
        logic        exp_err, pi, pd, dwe, gwe;
        logic [31:0] ia, da, dwd, ga, gwd, rd_pend;
        logic [31:0] m_if, m_d;
        logic [5:0]  idx;
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        tick; tick;
        reset = 1'b0;
        phase = 0; gport = 0; busy_n = 0; wait_n = 0; last_port = 2;
        exp_ack = 0; exp_err = 1'b0; pi = 1'b0; pd = 1'b0;
        m_if = 32'h0; m_d = 32'h0; rd_pend = 32'h0;
        ia = 32'h0; da = 32'h0; dwd = 32'h0; dwe = 1'b0; ga = 32'h0; gwd = 32'h0; gwe = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (!pi && $urandom_range(0, 2) == 0) begin
                pi = 1'b1; ia = 32'($urandom_range(0, 63)) << 2;
            end
            if (!pd && $urandom_range(0, 2) == 0) begin
                pd = 1'b1; da = 32'($urandom_range(0, 63)) << 2;
                dwe = 1'($urandom_range(0, 1)); dwd = $urandom;
            end
            if_req = pi; if_addr = pi ? ia : $urandom;
            d_req = pd; d_addr = pd ? da : $urandom;
            d_we = pd ? dwe : 1'($urandom_range(0, 1)); d_wdata = pd ? dwd : $urandom;
            @(negedge clk);
            n_vec++; if (if_ack !== (exp_ack == 1) || d_ack !== (exp_ack == 2) || err !== (exp_ack != 0 && exp_err)) begin
                n_bad++; $display("FAIL rnd_ack c%0d got if=%0b d=%0b err=%0b want port=%0d err=%0b", c, if_ack, d_ack, err, exp_ack, exp_err);
            end
            if (exp_ack == 1) begin pi = 1'b0; if (!exp_err) m_if = rd_pend; end
            if (exp_ack == 2) begin pd = 1'b0; if (!exp_err && !gwe) m_d = rd_pend; end
            n_vec++; if (if_rdata !== m_if || d_rdata !== m_d) begin
                n_bad++; $display("FAIL rnd_rdata c%0d got %h/%h want %h/%h", c, if_rdata, d_rdata, m_if, m_d);
            end
            n_vec++; if (stall !== ((if_req && exp_ack != 1) || (d_req && exp_ack != 2))) begin
                n_bad++; $display("FAIL rnd_stall c%0d got %0b", c, stall);
            end
            exp_ack = 0; exp_err = 1'b0;
            mem_ready = 1'b0; mem_rdata = $urandom;
            if (phase == 1) begin
                n_vec++; if (mem_req !== 1'b1 || mem_addr !== ga || mem_we !== gwe || (gwe && mem_wdata !== gwd)) begin
                    n_bad++; $display("FAIL rnd_cmd c%0d got req=%0b addr=%h we=%0b wd=%h want 1/%h/%0b/%h", c, mem_req, mem_addr, mem_we, mem_wdata, ga, gwe, gwd);
                end
                if (busy_n == wait_n) begin
                    idx = ga[7:2];
                    mem_ready = 1'b1;
                    if (gwe) mem_model[idx] = gwd;
                    else mem_rdata = mem_model[idx];
                    rd_pend = mem_model[idx];
                    exp_ack = gport; phase = 2;
                end else if (busy_n == TIMEOUT - 2) begin
                    exp_ack = gport; exp_err = 1'b1; phase = 2;
                end
                busy_n++;
            end else begin
                n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rnd_idle_req c%0d got %0b want 0", c, mem_req); end
                mem_ready = 1'($urandom_range(0, 1));
                if (phase == 2) begin
                    phase = 0;
                end else begin
                    gport = 0;
                    if (if_req && (!d_req || last_port == 2)) gport = 1;
                    else if (d_req) gport = 2;
                    if (gport == 1) begin ga = ia; gwe = 1'b0; gwd = 32'h0; end
                    if (gport == 2) begin ga = da; gwe = dwe; gwd = dwd; end
                    if (gport != 0) begin
                        phase = 1; busy_n = 0; last_port = gport;
                        wait_n = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 4);
                    end
                end
            end
            tick;
        end
        mem_ready = 1'b0; if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        exp_if = 32'h0; exp_d = 32'h0;
        test_reset;
        test_fetch;
        test_tie_order;
        test_store;
        test_timeout;
        test_reset_mid;
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: max wait cycles on memory before abort.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port if_req  input  1  fetch request, held until if_ack.
REQ-007 SHALL have port if_addr  input  ADDR_W  fetch address (the PC).
REQ-008 SHALL have port if_rdata  output  DATA_W  fetched instruction.
REQ-009 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-010 SHALL have port d_req  input  1  data request, held until d_ack.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  input  ADDR_W  data address (ALU result).
REQ-013 SHALL have port d_wdata  input  DATA_W  store data.
REQ-014 SHALL have port d_rdata  output  DATA_W  load data.
REQ-015 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-016 SHALL have port err  output  1  pulses with an ack when that access timed out.
REQ-017 SHALL have port mem_req  output  1  request to the single-port unified memory.
REQ-018 SHALL have port mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  memory command fields.
REQ-019 SHALL have port mem_rdata  input  DATA_W  memory read data, valid with mem_ready.
REQ-020 SHALL have port mem_ready  input  1  memory completion, any latency >= 0 cycles after mem_req.
REQ-021 SHALL have port stall  output  1  freezes the program counter.

Function
REQ-022 SHALL use FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-023 In IDLE, single pending request SHALL be granted next cycle (BUSY_I or BUSY_D).
REQ-024 In IDLE with both pending, SHALL grant the port not granted last (round-robin via last_grant).
REQ-025 At grant, SHALL latch address, we, wdata; mem_* driven from latches, so requester changes mid-access have no effect.
REQ-026 mem_req SHALL be 1 exactly in BUSY_I/BUSY_D; mem_we forced 0 in BUSY_I.
REQ-027 On mem_ready in BUSY_x, SHALL capture mem_rdata (reads only) into that port's rdata register and go to RESP; captured rdata is visible when the ack pulses in RESP.
REQ-028 In RESP, SHALL pulse the granted port's ack for exactly one cycle, then return to IDLE.
REQ-029 Minimum latency: grant to ack = 2 cycles with mem_ready in first BUSY cycle; a request at IDLE completes in 3 cycles.
REQ-030 Requests SHALL be sampled only in IDLE; a req still high in IDLE after its ack counts as new.
REQ-031 Stores SHALL leave d_rdata unchanged; if_rdata/d_rdata hold until next read capture.
REQ-032 Wait counter SHALL clear on grant and increment each BUSY cycle without mem_ready; reaching TIMEOUT-1 without ready SHALL drop mem_req, go to RESP, and assert err with the ack.
REQ-033 mem_ready outside BUSY SHALL be ignored.
REQ-034 stall SHALL equal (if_req & ~if_ack) | (d_req & ~d_ack), combinational.

Reset
REQ-035 reset SHALL force IDLE, mem_req=0, mem_we=0, acks=0, err=0, rdata regs=0, counter=0, last_grant=DATA (fetch wins first tie).
REQ-036 reset mid-access SHALL abort silently: no ack, no err, mem_req low next cycle.

Structure
REQ-037 FSM state enum and last_grant encoding SHALL live in shared package riscv_pkg.
REQ-038 Design SHALL be one module, no sub-modules; counter width = clog2(TIMEOUT).

Verification
REQ-039 Fetch only, if_addr=0x10, mem_ready 1st BUSY cycle, mem_rdata=0x00500093 -> if_ack cycle 3, if_rdata=0x00500093, stall low after.
REQ-040 Both req same cycle after reset -> fetch first, data second; repeat -> order alternates.
REQ-041 Store d_addr=0x40 d_wdata=0xDEADBEEF, 3 wait cycles -> mem_we=1, fields stable 4 cycles, d_ack once, d_rdata unchanged.
REQ-042 mem_ready never asserted, TIMEOUT=16 -> mem_req drops after 15 BUSY cycles, ack+err pulse together.
REQ-043 reset asserted in BUSY_D -> IDLE next cycle, no d_ack, mem_req=0.
